// File: rtl/frequency_period_meter.sv
// -----------------------------------------------------------------------------
// frequency_period_meter
//
// Purpose:
//   Measures the half-period of a toggling tone signal in system-clock cycles.
//   It sits on the audio channel debug/self-check path, watching a channel's
//   frequency-timer output so hardware can confirm the programmed period.
//   Every completed interval between two tone edges is reported with a
//   one-cycle valid strobe. Lock is declared after LOCK_COUNT identical
//   measurements in a row. A timeout pulse flags loss of signal.
//
// Parameters:
//   WIDTH      - width of the interval counter and of the measurement.
//   LOCK_COUNT - identical measurements in a row needed for lock (2..15).
//   TIMEOUT    - cycles without an edge before a timeout (<= 2^WIDTH-1).
//
// Ports:
//   clock           in   system clock.
//   reset           in   synchronous, active-high reset.
//   tone_in         in   signal under measurement. It must already be
//                        synchronous to clock. Both edge polarities count.
//   enable          in   measurement enable. 0 forces IDLE.
//   period_measured out  most recent completed half-period, in clock cycles.
//   period_valid    out  one-cycle pulse when period_measured updates.
//   locked          out  LOCK_COUNT equal measurements seen in a row, with
//                        no change since.
//   timeout         out  one-cycle pulse after TIMEOUT cycles with no edge.
//   state_dbg       out  current FSM state (0 IDLE, 1 ARMED, 2 MEASURE).
//
// Interface timing:
//   There is no handshake. period_valid is a qualifier with no back-pressure.
//   period_measured may be sampled in any cycle where period_valid is 1. It
//   then holds that value until the next strobe.
// -----------------------------------------------------------------------------
module frequency_period_meter #(
    parameter int WIDTH      = 17,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 131071
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tone_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period_measured,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

    state_e           state_q, state_d;
    logic             tone_prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]       match_q, match_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             tone_edge;
    logic [WIDTH-1:0] cnt_inc;
    logic [3:0]       match_upd;

    // An edge of either polarity is a change from the previous sample.
    assign tone_edge = (tone_in != tone_prev_q);

    // TIMEOUT never exceeds CNT_MAX, so the timeout fires before the counter
    // could wrap. This guard only protects the counter if it is misconfigured.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Run length of equal measurements, including the one taken this cycle.
    // A match count of 0 means the run was broken by a timeout or by disable,
    // so the first value after that starts a new run even if it equals the
    // value still held in period_q.
    always_comb begin
        match_upd = 4'd1;
        if ((cnt_q == period_q) && (match_q != 4'd0)) begin
            match_upd = (match_q >= LOCK_V) ? LOCK_V : (match_q + 4'd1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = 1'b0;

        if (!enable) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            match_d  = 4'd0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d    = '0;
                    match_d  = 4'd0;
                    locked_d = 1'b0;
                    state_d  = ST_ARMED;
                end

                // The first interval after arming is partial, so it is only
                // used to align to an edge and is never reported. The counter
                // still runs here so that a dead input produces a timeout.
                ST_ARMED: begin
                    if (tone_edge) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MEASURE;
                    end else if (cnt_q == TIMEOUT_V) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        match_d   = 4'd0;
                        locked_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                // The edge is tested before the timeout. An edge that arrives
                // exactly when cnt reaches TIMEOUT is a valid measurement.
                ST_MEASURE: begin
                    if (tone_edge) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_ONE;
                        match_d  = match_upd;
                        locked_d = (match_upd == LOCK_V);
                    end else if (cnt_q == TIMEOUT_V) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        match_d   = 4'd0;
                        locked_d  = 1'b0;
                        state_d   = ST_ARMED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    match_d  = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tone_prev_q <= 1'b0;
            cnt_q       <= '0;
            match_q     <= 4'd0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tone_prev_q <= tone_in;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period_measured = period_q;
    assign period_valid    = valid_q;
    assign locked          = locked_q;
    assign timeout         = timeout_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_frequency_period_meter.sv
// -----------------------------------------------------------------------------
// tb_frequency_period_meter
//
// Drives the meter with directed tone patterns, then with randomised ones.
// After every clock, each output is checked against a reference model.
//
// The model works from event timestamps, not from a cycle counter. A
// measurement is the number of cycles between two edge timestamps. A timeout
// fires when the time since the reference point reaches TIMEOUT. Lock is true
// when the last LOCK_COUNT entries of the current run of measurements are
// all equal.
// -----------------------------------------------------------------------------
module tb_frequency_period_meter;

  localparam int WIDTH      = 17;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 20;

  // ---------------- clock / reset / DUT ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic             tone_in;
  logic             enable;
  logic [WIDTH-1:0] period_measured;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [1:0]       state_dbg;

  always #5 clock = ~clock;

  frequency_period_meter #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .tone_in         (tone_in),
    .enable          (enable),
    .period_measured (period_measured),
    .period_valid    (period_valid),
    .locked          (locked),
    .timeout         (timeout),
    .state_dbg       (state_dbg)
  );

  // ---------------- reference model ----------------
  int               vectors     = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  int               cyc = 0;
  int               m_mode;     // 0 off, 1 waiting for the first edge, 2 measuring
  int               ref_t;      // timestamp at which the interval count is zero
  logic             m_prev;
  int               run_q[$];   // measurements since the last break in the run
  logic [WIDTH-1:0] e_period;
  logic             e_valid;
  logic             e_locked;
  logic             e_timeout;

  function automatic logic run_is_locked();
    if (run_q.size() < LOCK_COUNT) return 1'b0;
    for (int i = 1; i < LOCK_COUNT; i++) begin
      if (run_q[run_q.size() - 1 - i] != run_q[run_q.size() - 1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advances the model by one clock, using the inputs sampled at this edge.
  task automatic model_step();
    logic edge_seen;
    int   meas;
    e_valid   = 1'b0;
    e_timeout = 1'b0;
    if (reset) begin
      m_mode   = 0;
      m_prev   = 1'b0;
      e_period = '0;
      e_locked = 1'b0;
      run_q.delete();
      exp_q.delete();
    end else begin
      edge_seen = (tone_in != m_prev);
      m_prev    = tone_in;
      if (!enable) begin
        m_mode   = 0;
        e_locked = 1'b0;
        run_q.delete();
      end else if (m_mode == 0) begin
        m_mode = 1;
        ref_t  = cyc + 1;
      end else if (edge_seen) begin
        if (m_mode == 2) begin
          meas     = cyc - ref_t;
          e_period = WIDTH'(meas);
          e_valid  = 1'b1;
          exp_q.push_back(WIDTH'(meas));
          run_q.push_back(meas);
          e_locked = run_is_locked();
        end
        m_mode = 2;
        ref_t  = cyc;
      end else if (cyc - ref_t == TIMEOUT) begin
        e_timeout = 1'b1;
        e_locked  = 1'b0;
        run_q.delete();
        m_mode    = 1;
        ref_t     = cyc + 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [WIDTH-1:0] exp_meas;
    vectors++;
    assert (period_measured === e_period) else begin
      miscompares++;
      $error("FAIL period_measured cyc=%0d: got %0d expected %0d", cyc, period_measured, e_period);
    end
    assert (period_valid === e_valid) else begin
      miscompares++;
      $error("FAIL period_valid cyc=%0d: got %b expected %b", cyc, period_valid, e_valid);
    end
    assert (locked === e_locked) else begin
      miscompares++;
      $error("FAIL locked cyc=%0d: got %b expected %b", cyc, locked, e_locked);
    end
    assert (timeout === e_timeout) else begin
      miscompares++;
      $error("FAIL timeout cyc=%0d: got %b expected %b", cyc, timeout, e_timeout);
    end
    if (e_valid && exp_q.size() > 0) begin
      exp_meas = exp_q.pop_front();
      assert (period_valid === 1'b1 && period_measured === exp_meas) else begin
        miscompares++;
        $error("FAIL measurement cyc=%0d: got valid=%b value=%0d expected value %0d",
               cyc, period_valid, period_measured, exp_meas);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge. The model samples them at
  // the next rising edge, which is also where the DUT samples them. Outputs are
  // checked 1 time unit after that edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic run_period(input int p, input int n_edges);
    for (int i = 0; i < n_edges; i++) begin
      tone_in = ~tone_in;
      repeat (p) tick();
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cur_p;
    int r;
    reset   = 1'b1;
    enable  = 1'b0;
    tone_in = 1'b0;
    m_mode  = 0;
    m_prev  = 1'b0;
    ref_t   = 0;
    hold(2);                       // reset state
    reset  = 1'b0;
    enable = 1'b1;
    hold(2);

    run_period(5, 8);              // first valid after second edge, lock at 4th
    run_period(9, 6);              // change drops lock immediately, re-lock
    run_period(7, 6);
    hold(25);                      // loss of signal -> timeout, period holds
    run_period(7, 4);              // fresh measurements after the timeout
    run_period(1, 12);             // edge every cycle
    run_period(TIMEOUT, 6);        // edge coincides with TIMEOUT: edge wins
    run_period(TIMEOUT + 1, 3);    // just too slow: timeouts
    run_period(12, 6);
    reset = 1'b1;                  // reset while locked
    tick();
    reset = 1'b0;
    run_period(12, 7);

    tone_in = ~tone_in;            // enable dropped mid-interval
    hold(3);
    enable = 1'b0;
    hold(5);
    tone_in = ~tone_in;
    hold(2);
    enable = 1'b1;
    run_period(6, 7);

    cur_p = 4;
    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        run_period(cur_p, $urandom_range(1, 6));
      end else if (r < 13) begin
        cur_p = $urandom_range(1, TIMEOUT + 4);
      end else if (r < 15) begin
        enable = 1'b0;
        hold($urandom_range(1, 4));
        enable = 1'b1;
      end else if (r == 15) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        hold($urandom_range(TIMEOUT - 5, TIMEOUT + 10));
      end
    end
    hold(3);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frequency_period_meter.md
Name: frequency_period_meter

Overview:
- Receive-side counterpart of the frequency timer: measures the half-period of an incoming toggling tone clock in system-clock cycles.
- Reports each measurement with a one-cycle valid strobe.
- Declares lock after a run of identical measurements and flags loss of signal via timeout.
- Sits on the audio channel debug/self-check path: measures a channel's frequency-timer output so hardware can confirm the programmed period.

Parameters:
- WIDTH, 17: width of the period counter and measurement; matches the frequency timer period width.
- LOCK_COUNT, 4: consecutive identical measurements required to assert locked; legal range 2..15.
- TIMEOUT, 131071: cycles without a tone edge before a timeout is declared; must be ≤ 2^WIDTH-1.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tone_in  input  1  toggling signal under measurement; synchronous to clock.
- enable  input  1  measurement enable; 0 forces IDLE.
- period_measured  output  WIDTH  most recent completed half-period, in clock cycles.
- period_valid  output  1  one-cycle pulse when period_measured updates.
- locked  output  1  LOCK_COUNT consecutive equal measurements seen, with no change since.
- timeout  output  1  one-cycle pulse when TIMEOUT cycles elapse without an edge.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: period_measured=0, period_valid=0, locked=0, timeout=0, state=IDLE, tone_prev=0, cnt=0, match_cnt=0.
- Edge detect: tone_prev <= tone_in every cycle; edge = (tone_in != tone_prev). Both polarities count.
- States:
  - IDLE: cnt=0, match_cnt=0, locked=0. Go to ARMED when enable=1.
  - ARMED: waits for the first edge. On edge: cnt<=1, go to MEASURE; no valid pulse, since the first interval is partial.
  - MEASURE: on edge: period_measured<=cnt, period_valid<=1 next cycle, cnt<=1. Otherwise cnt<=cnt+1.
- Timing: a source toggling every P cycles yields period_measured=P. period_valid is asserted in the cycle after the edge cycle (registered, 1-cycle latency) and lasts exactly one cycle.
- Lock tracking (MEASURE, on each measurement):
  - If the new value equals the previous period_measured and match_cnt≠0: match_cnt<=min(match_cnt+1, LOCK_COUNT).
  - Otherwise: match_cnt<=1.
  - locked = (match_cnt==LOCK_COUNT), registered; it updates in the same cycle period_valid asserts.
  - A differing measurement drops locked in that same cycle.
- Timeout: in ARMED or MEASURE, if cnt reaches TIMEOUT with no edge:
  - timeout pulses for one cycle; locked<=0; match_cnt<=0; cnt<=0.
  - state<=ARMED; period_measured holds its last value.
  - In ARMED, cnt also counts so timeout fires. cnt restarts at 1 on the ARMED edge.
- Saturation: cnt never wraps; TIMEOUT ≤ 2^WIDTH-1 guarantees timeout fires first.
- Simultaneous edge and cnt==TIMEOUT: the edge wins; the measurement is taken and no timeout is raised.
- enable deasserted mid-measurement: next cycle state=IDLE, locked=0, no valid pulse; period_measured holds.
- Reset mid-operation: all registers return to reset values on the next clock; pending valid/timeout pulses are cancelled.
- Consecutive edges (P=1): measured=1 each cycle; period_valid stays high continuously, one pulse per measurement.

Test Plan:
- Reset, enable=1, tone_in toggling every 5 cycles -> first valid after the second edge; period_measured=5; locked=1 at the 4th consecutive valid.
- Locked at P=5, source switches to P=9 -> next valid carries 9 and locked=0 that cycle; locked returns after 4 valids of 9.
- Locked at P=7, TIMEOUT=20, tone_in held constant -> timeout pulse exactly 20 cycles after the last edge; locked=0; period_measured stays 7; next two edges yield a fresh measurement.
- P=1 toggle every cycle -> period_measured=1 every cycle; locked after 4; no timeout.
- Reset asserted for 1 cycle while locked at P=12 -> all outputs 0 next cycle; re-lock requires the ARMED discard plus 4 measurements.
- enable dropped mid-interval, then raised -> no valid while disabled; the first interval after re-enable is discarded.
